rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 138 +++++++++++++
 tb/tb_rom_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: two-requester round-robin arbiter in front of a combinational ROM.
//
// Each read is a three-cycle transaction. Requests are sampled only in IDLE;
// the winner's address is registered onto rom_addr. In READ the ROM word is
// captured into rdata and the owner's ack is raised. In RESP the ack is
// dropped and the FSM returns to IDLE. This gives one read per three cycles
// and exactly one-cycle ack pulses.
//
// Ports:
//   clk              single clock, rising edge
//   rst_n            synchronous active-low reset
//   req0, req1       level read requests
//   addr0, addr1     read addresses, held while the matching req is high
//   ack0, ack1       one-cycle pulse; rdata is valid for that requester
//   rdata            registered read data, shared by both requesters
//   rom_addr         registered address to the combinational ROM
//   rom_data         ROM read data for rom_addr
//   busy             high whenever the FSM is not in IDLE
//
// Configuration:
//   ROM_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins ties and no
//                          last-grant history is kept. When undefined, ties
//                          go to the requester that was not granted last.

module rom_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic owner;   // requester that holds the current transaction
  logic winner;  // arbitration result, meaningful only when a req is high
  logic any_req;

`ifndef ROM_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif

  assign any_req = req0 | req1;
  assign busy    = (state != IDLE);

  // Arbitration. A lone request always wins. On a tie, the fixed-priority
  // build favours requester 0. The round-robin build favours whoever was not
  // granted last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    winner = 1'b0;
    if (req0 && req1) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_grant;
`endif
    end else if (req1) begin
      winner = 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = READ;
      READ:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of the order of statements.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Datapath registers. Reset also aborts a transaction that is in flight,
  // because the owner's ack is only raised from READ.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      rom_addr   <= '0;
      owner      <= 1'b0;
`ifndef ROM_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;  // requester 0 wins the first tie
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            rom_addr   <= winner ? addr1 : addr0;
            owner      <= winner;
`ifndef ROM_ARB_FIXED_PRIO_EN
            last_grant <= winner;
`endif
          end
        end
        READ: begin
          rdata <= rom_data;
          ack0  <= ~owner;
          ack1  <= owner;
        end
        RESP: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
        default: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter.
//
// The reference model works at the transaction level. A grant seen at an edge
// makes the owner's ack and the ROM word visible after the following edge. The
// ack clears one edge later, and arbitration resumes on the edge after that.
// Directed scenarios cover the reset, single-read, tie, dropped-request,
// mid-transaction reset and back-to-back cases. A randomized run follows.

module tb_rom_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;

`ifdef ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          busy;

  logic [DW-1:0] rom [256];

  int checks = 0;
  int errors = 0;

  // Transaction-level model state.
  int            m_phase;      // edges since grant: 0 idle, 1 waiting read, 2 ack out
  bit            m_last;
  bit            m_owner;
  bit            m_ack0, m_ack1, m_busy;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_rom_addr;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  rom_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .req1     (req1),
    .addr0    (addr0),
    .addr1    (addr1),
    .ack0     (ack0),
    .ack1     (ack1),
    .rdata    (rdata),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs that were stable across it.
  task automatic model_edge();
    bit win;
    if (!rst_n) begin
      m_phase = 0; m_last = 1'b1; m_owner = 1'b0;
      m_ack0 = 1'b0; m_ack1 = 1'b0;
      m_rdata = '0; m_rom_addr = '0;
    end else begin
      m_ack0 = 1'b0;
      m_ack1 = 1'b0;
      if (m_phase == 1) begin
        m_rdata = rom[m_rom_addr];
        m_ack0  = !m_owner;
        m_ack1  = m_owner;
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else if (req0 || req1) begin
        if (req0 && req1) win = FIXED ? 1'b0 : !m_last;
        else              win = req1;
        m_rom_addr = win ? addr1 : addr0;
        m_owner    = win;
        m_last     = win;
        m_phase    = 1;
      end
    end
    m_busy = (m_phase != 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("ack0",     32'(ack0),     32'(m_ack0));
    check("ack1",     32'(ack1),     32'(m_ack1));
    check("rdata",    32'(rdata),    32'(m_rdata));
    check("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
    check("busy",     32'(busy),     32'(m_busy));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin : main
    bit exp_who;
    bit prev_ack0;
    int n_acks;

    rom[0] = 8'h09; rom[1] = 8'h15; rom[2] = 8'h1C; rom[3] = 8'h2A;
    for (int i = 4; i < 256; i++) rom[i] = DW'($urandom);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;

    // Reset state, against fixed constants.
    do_reset();
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_rdata", 32'(rdata),    32'd0);
    check("rst_addr",  32'(rom_addr), 32'd0);
    check("rst_acks",  32'({ack0, ack1}), 32'd0);

    // Single read from requester 0.
    req0 = 1'b1; addr0 = 8'd1;
    step();
    check("s1_busy", 32'(busy), 32'd1);
    step();
    check("s1_ack0",  32'(ack0),  32'd1);
    check("s1_ack1",  32'(ack1),  32'd0);
    check("s1_rdata", 32'(rdata), 32'h15);
    req0 = 1'b0;
    step();
    check("s1_ack0_pulse", 32'(ack0), 32'd0);
    step();

    // Both requesting from reset: acks alternate (or stay on 0 when fixed).
    do_reset();
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'd0; addr1 = 8'd3;
    exp_who = 1'b0;
    n_acks = 0;
    for (int c = 0; c < 13; c++) begin
      step();
      if (ack0 || ack1) begin
        n_acks++;
        check("tie_who",   32'(ack1),  32'(exp_who));
        check("tie_rdata", 32'(rdata), exp_who ? 32'h2A : 32'h09);
        if (!FIXED) exp_who = !exp_who;
      end
    end
    check("tie_count", 32'(n_acks), 32'd4);
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();

    // Request dropped during READ still completes.
    req1 = 1'b1; addr1 = 8'd2;
    step();
    req1 = 1'b0;
    step();
    check("drop_ack1",  32'(ack1),  32'd1);
    check("drop_rdata", 32'(rdata), 32'h1C);
    step();
    check("drop_busy", 32'(busy), 32'd0);
    step();
    check("drop_idle", 32'(busy), 32'd0);

    // Reset during READ aborts with no ack.
    req0 = 1'b1; addr0 = 8'd3;
    step();
    rst_n = 1'b0; req0 = 1'b0;
    step();
    check("abort_acks",  32'({ack0, ack1}), 32'd0);
    check("abort_rdata", 32'(rdata),    32'd0);
    check("abort_addr",  32'(rom_addr), 32'd0);
    check("abort_busy",  32'(busy),     32'd0);
    rst_n = 1'b1; req1 = 1'b1; addr1 = 8'd0;
    step();
    step();
    check("abort_ack1",  32'(ack1),  32'd1);
    check("abort_data1", 32'(rdata), 32'h09);
    req1 = 1'b0;
    step(); step();

    // Back-to-back reads on requester 0 with stepping address.
    req0 = 1'b1;
    prev_ack0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr0 = AW'(k);
      for (int c = 0; c < 3; c++) begin
        step();
        check("b2b_no_double", 32'(prev_ack0 & ack0), 32'd0);
        prev_ack0 = ack0;
        if (c == 1) begin
          check("b2b_ack0",  32'(ack0),  32'd1);
          check("b2b_rdata", 32'(rdata), 32'(rom[k]));
        end
      end
    end
    req0 = 1'b0;
    step(); step();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      req0  = $urandom_range(0, 2) != 0;
      req1  = $urandom_range(0, 2) != 0;
      addr0 = AW'($urandom);
      addr1 = AW'($urandom);
      step();
      check("rnd_onehot", 32'(ack0 & ack1), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
